// File: rtl/log_pe_pkg.sv
// Shared types and widths for the 16b fractional log-domain PE.
// Optional feature macro: LOG_NORM_SIGNED_EN (two's complement operands, sign tracked).
package log_pe_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFF_W  = 4;
  localparam int unsigned FRAC_W = DATA_W - 1;

  // Normalised operand as held in the output stage and seen by the log adder
  typedef struct packed {
    logic              sign;
    logic              is_zero;
    logic [OFF_W-1:0]  shift_offset;
    logic [FRAC_W-1:0] frac_norm;
  } log_norm_t;

  // Two's complement magnitude; the most negative value maps onto itself (0x8000)
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/lod16.sv
// Combinational 16-bit leading-one detector.
// pos_c is the index of the most significant set bit (0 for a zero input); zero_c flags an all-zero input.
module lod16
  import log_pe_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [OFF_W-1:0]  pos_c,
  output logic              zero_c
);

  // Priority scan upward so the highest set bit wins
  always_comb begin
    pos_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (data[i]) pos_c = OFF_W'(i);
    end
  end

  // All-zero flag
  assign zero_c = ~|data;

endmodule

// File: rtl/log_norm_stage.sv
// Upstream normaliser for the log-domain PE: leading-one detect plus fraction
// alignment, with a settle cycle so the registered log-offset LUT fed by
// shift_offset is aligned with the fields when out_vld rises.
// Optional feature macro: LOG_NORM_SIGNED_EN (in_data is two's complement,
// detection runs on |in_data|, sign is registered with the operand).
module log_norm_stage
  import log_pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic [OFF_W-1:0]  shift_offset,
  output logic [FRAC_W-1:0] frac_norm,
  output logic              is_zero,
  output logic              sign,
  output logic              out_vld,
  input  logic              out_rdy
);

  // Stage A: captured raw operand
  logic              a_vld;
  logic [DATA_W-1:0] a_data;

  // Stage B: held normalised operand
  logic              b_vld;
  logic              b_settled;
  log_norm_t         b_q;

  // Handshake terms
  logic              in_fire;
  logic              out_fire;
  logic              b_load;

  // Normaliser datapath on stage A
  logic              a_sign;
  logic [DATA_W-1:0] a_mag;
  logic [OFF_W-1:0]  lod_pos;
  logic              lod_zero;
  log_norm_t         nrm;

`ifdef LOG_NORM_SIGNED_EN
  // Signed operands: detect on the magnitude, keep the sign bit alongside
  assign a_sign = a_data[DATA_W-1];
  assign a_mag  = abs_val(a_data);
`else
  // Unsigned operands: the word is the magnitude
  assign a_sign = 1'b0;
  assign a_mag  = a_data;
`endif

  lod16 u_lod (
    .data   (a_mag),
    .pos_c  (lod_pos),
    .zero_c (lod_zero)
  );

  // Shift the leading one out of the top and keep the bits below it, MSB-aligned
  always_comb begin
    nrm              = '0;
    nrm.sign         = a_sign;
    nrm.is_zero      = lod_zero;
    nrm.shift_offset = lod_pos;
    nrm.frac_norm    = FRAC_W'(a_mag << (OFF_W'(DATA_W - 1) - lod_pos));
  end

  // Handshake: B only presents after its settle cycle; A drains into B whenever B frees up
  assign out_vld  = b_vld && b_settled;
  assign out_fire = out_vld && out_rdy;
  assign b_load   = a_vld && (!b_vld || out_fire);
  assign in_rdy   = !a_vld || b_load;
  assign in_fire  = in_vld && in_rdy;

  // Stage A capture register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld  <= 1'b0;
      a_data <= '0;
    end else if (in_fire) begin
      a_vld  <= 1'b1;
      a_data <= in_data;
    end else if (b_load) begin
      a_vld  <= 1'b0;
    end
  end

  // Stage B hold register; a fresh load spends one cycle unsettled while the LUT registers shift_offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld     <= 1'b0;
      b_settled <= 1'b0;
      b_q       <= '0;
    end else if (b_load) begin
      b_vld     <= 1'b1;
      b_settled <= 1'b0;
      b_q       <= nrm;
    end else if (out_fire) begin
      b_vld     <= 1'b0;
      b_settled <= 1'b0;
    end else if (b_vld) begin
      b_settled <= 1'b1;
    end
  end

  // Outputs come straight from the stage B register
  assign shift_offset = b_q.shift_offset;
  assign frac_norm    = b_q.frac_norm;
  assign is_zero      = b_q.is_zero;
  assign sign         = b_q.sign;

endmodule

// File: tb/tb_log_norm_stage.sv
// Directed self-checking bench for log_norm_stage (latency, zero/one corners,
// streaming throughput, backpressure hold, reset mid-flight). Builds for
// either setting of LOG_NORM_SIGNED_EN.
module tb_log_norm_stage;
  import log_pe_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  shift_offset;
  logic [FRAC_W-1:0] frac_norm;
  logic              is_zero;
  logic              sign;
  logic              out_vld;
  logic              out_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vec_op[$];
  log_norm_t   vec_exp[$];

  log_norm_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_data      (in_data),
    .shift_offset (shift_offset),
    .frac_norm    (frac_norm),
    .is_zero      (is_zero),
    .sign         (sign),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] op, input logic s, input logic z,
                         input logic [3:0] off, input logic [14:0] fr);
    log_norm_t e;
    e.sign = s; e.is_zero = z; e.shift_offset = off; e.frac_norm = fr;
    vec_op.push_back(op);
    vec_exp.push_back(e);
  endtask

  task automatic clear_vec();
    vec_op.delete();
    vec_exp.delete();
  endtask

  // Stream the loaded vectors; out_rdy is low for cycles [stall_lo, stall_hi)
  task automatic run_stream(input string name, input int stall_lo, input int stall_hi,
                            input bit strict);
    int n, idx, oidx, cyc, gap, max_gap, last_out;
    bit prev_stall;
    log_norm_t cur, prev;
    n = vec_op.size(); idx = 0; oidx = 0; cyc = 0; gap = 0; max_gap = 0; last_out = -1;
    prev_stall = 1'b0; prev = '0;
    while (oidx < n && cyc < 200) begin
      @(negedge clk);
      in_vld  = (idx < n);
      in_data = (idx < n) ? vec_op[idx] : 16'hDEAD;
      out_rdy = !(cyc >= stall_lo && cyc < stall_hi);
      #1;
      cur.sign = sign; cur.is_zero = is_zero;
      cur.shift_offset = shift_offset; cur.frac_norm = frac_norm;
      if (prev_stall) begin
        check({name, "_hold_vld"}, 32'(out_vld), 32'd1);
        check({name, "_hold_fields"}, {11'b0, cur}, {11'b0, prev});
      end
      if (stall_hi > stall_lo && cyc == stall_hi - 1) begin
        check({name, "_full_in_rdy"}, 32'(in_rdy), 32'd0);
        check({name, "_full_accepts"}, 32'(idx), 32'd2);
      end
      if (in_vld && !in_rdy) gap++; else gap = 0;
      if (gap > max_gap) max_gap = gap;
      if (in_vld && in_rdy) idx++;
      if (out_vld && out_rdy) begin
        check({name, "_off"},  32'(shift_offset), 32'(vec_exp[oidx].shift_offset));
        check({name, "_frac"}, 32'(frac_norm),    32'(vec_exp[oidx].frac_norm));
        check({name, "_zero"}, 32'(is_zero),      32'(vec_exp[oidx].is_zero));
        check({name, "_sign"}, 32'(sign),         32'(vec_exp[oidx].sign));
        if (strict && last_out >= 0) check({name, "_spacing"}, 32'(cyc - last_out), 32'd2);
        last_out = cyc;
        oidx++;
      end
      prev_stall = out_vld && !out_rdy;
      prev = cur;
      cyc++;
    end
    check({name, "_count"}, 32'(oidx), 32'(n));
    if (strict) check({name, "_rdy_gap"}, 32'(max_gap), 32'd1);
    // Nothing further may emerge once all operands are out
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_vld = 1'b0; in_data = 16'hBEEF; out_rdy = 1'b1;
      #1;
      check({name, "_drain_vld"}, 32'(out_vld), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_off",     32'(shift_offset), 32'd0);
    check("rst_frac",    32'(frac_norm), 32'd0);
    check("rst_zero",    32'(is_zero), 32'd0);
    check("rst_sign",    32'(sign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);

    // Single operand latency: accept edge E, shift_offset at E+1, out_vld after E+2
    @(negedge clk);
    in_vld = 1'b1; in_data = 16'h0A00; out_rdy = 1'b1;
    #1;
    check("lat_in_rdy", 32'(in_rdy), 32'd1);
    @(negedge clk);
    in_vld = 1'b0; in_data = 16'hBEEF;
    #1;
    check("lat_e0_vld", 32'(out_vld), 32'd0);
    @(negedge clk);
    #1;
    check("lat_e1_vld", 32'(out_vld), 32'd0);
    check("lat_e1_off", 32'(shift_offset), 32'd11);
    @(negedge clk);
    #1;
    check("lat_e2_vld",  32'(out_vld), 32'd1);
    check("lat_e2_off",  32'(shift_offset), 32'd11);
    check("lat_e2_frac", 32'(frac_norm), 32'h2000);
    check("lat_e2_zero", 32'(is_zero), 32'd0);
    @(negedge clk);
    #1;
    check("lat_e3_vld", 32'(out_vld), 32'd0);

    // Zero, one and sign-sensitive corners
    clear_vec();
    add_vec(16'h0000, 1'b0, 1'b1, 4'd0,  15'h0000);
    add_vec(16'h0001, 1'b0, 1'b0, 4'd0,  15'h0000);
    add_vec(16'h7FFF, 1'b0, 1'b0, 4'd14, 15'h7FFE);
`ifdef LOG_NORM_SIGNED_EN
    add_vec(16'hFFF0, 1'b1, 1'b0, 4'd4,  15'h0000);
    add_vec(16'h8000, 1'b1, 1'b0, 4'd15, 15'h0000);
    add_vec(16'hFFFF, 1'b1, 1'b0, 4'd0,  15'h0000);
`else
    add_vec(16'hFFF0, 1'b0, 1'b0, 4'd15, 15'h7FF0);
    add_vec(16'h8000, 1'b0, 1'b0, 4'd15, 15'h0000);
    add_vec(16'hFFFF, 1'b0, 1'b0, 4'd15, 15'h7FFF);
`endif
    run_stream("corner", 0, 0, 1'b0);

    // Back-to-back with no backpressure: one result every 2 cycles
    clear_vec();
`ifdef LOG_NORM_SIGNED_EN
    add_vec(16'h8000, 1'b1, 1'b0, 4'd15, 15'h0000);
`else
    add_vec(16'h8000, 1'b0, 1'b0, 4'd15, 15'h0000);
`endif
    add_vec(16'h00FF, 1'b0, 1'b0, 4'd7,  15'h7F00);
    add_vec(16'h1234, 1'b0, 1'b0, 4'd12, 15'h11A0);
    run_stream("stream", 0, 0, 1'b1);

    // Downstream stalled for 10 cycles while streaming
    clear_vec();
    add_vec(16'h0100, 1'b0, 1'b0, 4'd8,  15'h0000);
    add_vec(16'h0003, 1'b0, 1'b0, 4'd1,  15'h4000);
    add_vec(16'h0A00, 1'b0, 1'b0, 4'd11, 15'h2000);
    add_vec(16'h4001, 1'b0, 1'b0, 4'd14, 15'h0002);
    run_stream("stall", 0, 10, 1'b0);

    // Fill A and B under backpressure, then reset mid-flight
    out_rdy = 1'b0;
    @(negedge clk);
    in_vld = 1'b1; in_data = 16'h0100;
    @(negedge clk);
    in_data = 16'h0200;
    @(negedge clk);
    in_vld = 1'b0; in_data = 16'hBEEF;
    @(negedge clk);
    #1;
    check("pre_rst_in_rdy", 32'(in_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_vld), 32'd0);
    check("mid_rst_off", 32'(shift_offset), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    check("post_rst_vld",    32'(out_vld), 32'd0);
    clear_vec();
    add_vec(16'h0004, 1'b0, 1'b0, 4'd2, 15'h0000);
    run_stream("after_rst", 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
